// File: rtl/dm_sba_pkg.sv
// Shared debug-module constants: DMI register map, op codes, sbcs layout and sberror codes.
// sbcs_pack() assembles the architectural sbcs read value from the stored R/W fields.
package dm_sba_pkg;

  localparam logic [5:0] DMI_SBCS       = 6'h38;
  localparam logic [5:0] DMI_SBADDRESS0 = 6'h39;
  localparam logic [5:0] DMI_SBDATA0    = 6'h3c;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam int SBCS_SBVERSION_LSB  = 29;
  localparam int SBCS_SBBUSYERROR    = 22;
  localparam int SBCS_SBBUSY         = 21;
  localparam int SBCS_SBREADONADDR   = 20;
  localparam int SBCS_SBACCESS_LSB   = 17;
  localparam int SBCS_SBAUTOINC      = 16;
  localparam int SBCS_SBREADONDATA   = 15;
  localparam int SBCS_SBERROR_LSB    = 12;
  localparam int SBCS_SBASIZE_LSB    = 5;
  localparam int SBCS_SBACCESS32     = 2;

  localparam logic [2:0] SBERR_NONE    = 3'd0;
  localparam logic [2:0] SBERR_TIMEOUT = 3'd1;
  localparam logic [2:0] SBERR_BADADDR = 3'd2;
  localparam logic [2:0] SBERR_ALIGN   = 3'd3;
  localparam logic [2:0] SBERR_SIZE    = 3'd4;

  localparam logic [2:0] SBVERSION   = 3'd1;
  localparam logic [6:0] SBASIZE     = 7'd32;
  localparam logic [2:0] SBACCESS_32 = 3'd2;

  typedef struct packed {
    logic       busyerror;
    logic       readonaddr;
    logic [2:0] access;
    logic       autoinc;
    logic       readondata;
    logic [2:0] error;
  } sbcs_rw_t;

  function automatic logic [31:0] sbcs_pack(input sbcs_rw_t f, input logic busy);
    logic [31:0] v;
    v = '0;
    v[SBCS_SBVERSION_LSB +: 3] = SBVERSION;
    v[SBCS_SBBUSYERROR]        = f.busyerror;
    v[SBCS_SBBUSY]             = busy;
    v[SBCS_SBREADONADDR]       = f.readonaddr;
    v[SBCS_SBACCESS_LSB +: 3]  = f.access;
    v[SBCS_SBAUTOINC]          = f.autoinc;
    v[SBCS_SBREADONDATA]       = f.readondata;
    v[SBCS_SBERROR_LSB +: 3]   = f.error;
    v[SBCS_SBASIZE_LSB +: 7]   = SBASIZE;
    v[SBCS_SBACCESS32]         = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dm_sba_bus_if.sv
// Single-word bus master: registers the request at start, holds it until mem_ack, then idles.
// Optional watchdog under DM_SBA_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES request cycles.
module dm_sba_bus_if
  import dm_sba_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_was_rd,
  output logic        o_fault,
  output logic [2:0]  o_fault_code,
  output logic [31:0] o_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  logic [1:0] r_state;
  logic       w_ack;
  logic       w_expire;
  logic       w_end;

  assign w_ack = (r_state != ST_IDLE) && mem_ack;

`ifdef DM_SBA_TIMEOUT_EN
  localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);

  logic [TO_W-1:0] r_cnt;

  // Counter value equals completed request cycles; expiry lands on the TIMEOUT_CYCLES-th one.
  assign w_expire = (r_state != ST_IDLE) && !mem_ack &&
                    (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_IDLE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  assign w_end = w_ack || w_expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_start) begin
        r_state   <= i_we ? ST_WR : ST_RD;
        mem_req   <= 1'b1;
        mem_we    <= i_we;
        mem_addr  <= i_addr;
        mem_wdata <= i_wdata;
      end
    end else if (w_end) begin
      r_state <= ST_IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = w_end;
  assign o_was_rd     = (r_state == ST_RD);
  assign o_fault      = (w_ack && mem_err) || w_expire;
  assign o_fault_code = w_expire ? SBERR_TIMEOUT : SBERR_BADADDR;
  assign o_rdata      = mem_rdata;

endmodule

// File: rtl/dm_sba.sv
// Debug-module system-bus access: sbcs/sbaddress0/sbdata0 over DMI, one response per request.
// Bus accesses run in dm_sba_bus_if; DM_SBA_TIMEOUT_EN compiles in its watchdog.
module dm_sba
  import dm_sba_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmi_req_valid,
  output logic        dmi_req_ready,
  input  logic [5:0]  dmi_req_addr,
  input  logic [31:0] dmi_req_data,
  input  logic [1:0]  dmi_req_op,
  output logic        dmi_resp_valid,
  input  logic        dmi_resp_ready,
  output logic [31:0] dmi_resp_data,
  output logic [1:0]  dmi_resp_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata
);

  logic        r_resp_vld;
  logic [31:0] r_resp_dat;
  sbcs_rw_t    r_sbcs;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  logic        w_accept, w_rd, w_wr;
  logic        w_sel_cs, w_sel_addr, w_sel_data;
  logic        w_busy, w_done, w_was_rd, w_fault;
  logic [2:0]  w_fault_code;
  logic [31:0] w_bus_rdata;
  logic        w_busy_hit, w_trig, w_err_free, w_size_bad, w_align_bad;
  logic        w_start, w_start_we;
  logic [31:0] w_chk_addr, w_start_wdata, w_sbcs_val, w_rd_dat;

  assign dmi_req_ready  = !r_resp_vld && !rst;
  assign dmi_resp_valid = r_resp_vld;
  assign dmi_resp_data  = r_resp_dat;
  assign dmi_resp_op    = 2'b00;

  assign w_accept   = dmi_req_valid && dmi_req_ready;
  assign w_rd       = w_accept && (dmi_req_op == DMI_OP_READ);
  assign w_wr       = w_accept && (dmi_req_op == DMI_OP_WRITE);
  assign w_sel_cs   = (dmi_req_addr == DMI_SBCS);
  assign w_sel_addr = (dmi_req_addr == DMI_SBADDRESS0);
  assign w_sel_data = (dmi_req_addr == DMI_SBDATA0);

  // Busy is the registered FSM state, so a request colliding with mem_ack still sees busy.
  assign w_busy_hit = w_busy && ((w_wr && (w_sel_addr || w_sel_data)) || (w_rd && w_sel_data));

  assign w_trig = !w_busy && ((w_wr && w_sel_addr && r_sbcs.readonaddr) ||
                              (w_wr && w_sel_data) ||
                              (w_rd && w_sel_data && r_sbcs.readondata));

  assign w_chk_addr    = (w_wr && w_sel_addr) ? dmi_req_data : r_addr;
  assign w_err_free    = (r_sbcs.error == SBERR_NONE) && !r_sbcs.busyerror;
  assign w_size_bad    = (r_sbcs.access != SBACCESS_32);
  assign w_align_bad   = |w_chk_addr[1:0];
  assign w_start       = w_trig && w_err_free && !w_size_bad && !w_align_bad;
  assign w_start_we    = w_wr && w_sel_data;
  assign w_start_wdata = w_start_we ? dmi_req_data : r_data;

  assign w_sbcs_val = sbcs_pack(r_sbcs, w_busy);

  always_comb begin
    w_rd_dat = '0;
    case (dmi_req_addr)
      DMI_SBCS:       w_rd_dat = w_sbcs_val;
      DMI_SBADDRESS0: w_rd_dat = r_addr;
      DMI_SBDATA0:    w_rd_dat = r_data;
      default:        w_rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_vld <= 1'b0;
      r_resp_dat <= '0;
      r_sbcs     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      if (r_resp_vld && dmi_resp_ready) begin
        r_resp_vld <= 1'b0;
      end
      if (w_accept) begin
        r_resp_vld <= 1'b1;
        r_resp_dat <= w_rd ? w_rd_dat : '0;
      end

      if (w_wr && w_sel_cs) begin
        r_sbcs.readonaddr <= dmi_req_data[SBCS_SBREADONADDR];
        r_sbcs.access     <= dmi_req_data[SBCS_SBACCESS_LSB +: 3];
        r_sbcs.autoinc    <= dmi_req_data[SBCS_SBAUTOINC];
        r_sbcs.readondata <= dmi_req_data[SBCS_SBREADONDATA];
        r_sbcs.error      <= r_sbcs.error & ~dmi_req_data[SBCS_SBERROR_LSB +: 3];
        if (dmi_req_data[SBCS_SBBUSYERROR]) begin
          r_sbcs.busyerror <= 1'b0;
        end
      end

      if (w_busy_hit) begin
        r_sbcs.busyerror <= 1'b1;
      end else begin
        if (w_wr && w_sel_addr) begin
          r_addr <= dmi_req_data;
        end
        if (w_wr && w_sel_data) begin
          r_data <= dmi_req_data;
        end
      end

      if (w_trig && w_err_free) begin
        if (w_size_bad) begin
          r_sbcs.error <= SBERR_SIZE;
        end else if (w_align_bad) begin
          r_sbcs.error <= SBERR_ALIGN;
        end
      end

      // Completion is last so a hardware error wins over a same-cycle write-1-to-clear.
      if (w_done) begin
        if (w_fault) begin
          r_sbcs.error <= w_fault_code;
        end else begin
          if (w_was_rd) begin
            r_data <= w_bus_rdata;
          end
          if (r_sbcs.autoinc) begin
            r_addr <= r_addr + 32'd4;
          end
        end
      end
    end
  end

  dm_sba_bus_if #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_if (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start),
    .i_we         (w_start_we),
    .i_addr       (w_chk_addr),
    .i_wdata      (w_start_wdata),
    .o_busy       (w_busy),
    .o_done       (w_done),
    .o_was_rd     (w_was_rd),
    .o_fault      (w_fault),
    .o_fault_code (w_fault_code),
    .o_rdata      (w_bus_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_err      (mem_err),
    .mem_rdata    (mem_rdata)
  );

endmodule
